// File: rtl/ipg_pkg.sv
// Shared IPG definitions: fire-type queue encodings and the default word width.
package ipg_pkg;
  localparam int IPG_DATA_WIDTH = 64;
  localparam int NUM_Q          = 3;

  typedef enum logic [1:0] {
    FIRE_RREQ  = 2'd0,
    FIRE_RRESP = 2'd1,
    FIRE_WREQ  = 2'd2,
    FIRE_NONE  = 2'd3
  } fire_type_e;
endpackage

// File: rtl/ivport_if.sv
// ivport bus: ingress push side plus the ovport select/fire read side.
interface ivport_if #(
  parameter int DATA_WIDTH = 64,
  parameter int QUE_DEPTH  = 6
);
  logic [DATA_WIDTH-1:0] fwd_ipg_data;
  logic                  fwd_en;
  logic                  rreq_valid, rresp_valid, wreq_valid;
  logic [1:0]            fire_type_sel;
  logic                  fire_en;
  logic [DATA_WIDTH-1:0] fire_ipg_data;
  logic                  rreq_empty, rresp_empty, wreq_empty;
  logic                  rreq_full, rresp_full, wreq_full;
  logic [QUE_DEPTH:0]    rreq_space, rresp_space, wreq_space;

  modport master (
    output fwd_ipg_data, fwd_en, rreq_valid, rresp_valid, wreq_valid,
           fire_type_sel, fire_en,
    input  fire_ipg_data, rreq_empty, rresp_empty, wreq_empty,
           rreq_full, rresp_full, wreq_full, rreq_space, rresp_space, wreq_space
  );

  modport slave (
    input  fwd_ipg_data, fwd_en, rreq_valid, rresp_valid, wreq_valid,
           fire_type_sel, fire_en,
    output fire_ipg_data, rreq_empty, rresp_empty, wreq_empty,
           rreq_full, rresp_full, wreq_full, rreq_space, rresp_space, wreq_space
  );
endinterface

// File: rtl/ipg_fifo.sv
// First-word-fall-through FIFO; push-when-full and pop-when-empty are ignored.
module ipg_fifo #(
  parameter int WIDTH      = 64,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      head,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   space
);
  localparam int ENTRIES = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] ENTRY_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem_q [ENTRIES];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
  logic                  push_ok, pop_ok;

  // Count only reaches 2^DEPTH_LOG2 when full, so its MSB is the full flag.
  assign empty = (cnt_q == '0);
  assign full  = cnt_q[DEPTH_LOG2];
  assign space = ENTRY_CNT - cnt_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/ivport.sv
// Virtual input port: three typed message queues filled from one ingress port,
// drained one queue at a time by the owning ovport.
module ivport
  import ipg_pkg::*;
#(
  parameter int DATA_WIDTH = IPG_DATA_WIDTH,
  parameter int QUE_DEPTH  = 6
) (
  input  logic     clk,
  input  logic     rst,
  ivport_if.slave  bus
);
  logic [NUM_Q-1:0]                 push, pop, empty, full;
  logic [NUM_Q-1:0][DATA_WIDTH-1:0] head;
  logic [NUM_Q-1:0][QUE_DEPTH:0]    space;
  logic [DATA_WIDTH-1:0]            fire_data;

  assign push = {bus.wreq_valid, bus.rresp_valid, bus.rreq_valid} & {NUM_Q{bus.fwd_en}};

  // Selector 3 matches no queue, so it neither pops nor shows data.
  always_comb begin
    pop       = '0;
    fire_data = '0;
    for (int q = 0; q < NUM_Q; q++) begin
      if (bus.fire_type_sel == 2'(q)) begin
        pop[q] = bus.fire_en;
        if (!empty[q]) fire_data = head[q];
      end
    end
  end

  for (genvar q = 0; q < NUM_Q; q++) begin : g_que
    ipg_fifo #(.WIDTH(DATA_WIDTH), .DEPTH_LOG2(QUE_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst),
      .push  (push[q]),
      .pop   (pop[q]),
      .wdata (bus.fwd_ipg_data),
      .head  (head[q]),
      .empty (empty[q]),
      .full  (full[q]),
      .space (space[q])
    );
  end

  assign bus.fire_ipg_data = fire_data;
  assign bus.rreq_empty    = empty[FIRE_RREQ];
  assign bus.rresp_empty   = empty[FIRE_RRESP];
  assign bus.wreq_empty    = empty[FIRE_WREQ];
  assign bus.rreq_full     = full[FIRE_RREQ];
  assign bus.rresp_full    = full[FIRE_RRESP];
  assign bus.wreq_full     = full[FIRE_WREQ];
  assign bus.rreq_space    = space[FIRE_RREQ];
  assign bus.rresp_space   = space[FIRE_RRESP];
  assign bus.wreq_space    = space[FIRE_WREQ];
endmodule

// File: tb/tb_ivport.sv
// Directed bench for ivport: reset, routing, gating, full/wrap and push+pop.
module tb_ivport;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  ivport_if #(.DATA_WIDTH(64), .QUE_DEPTH(6)) bus ();
  ivport #(.DATA_WIDTH(64), .QUE_DEPTH(6)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.fwd_en = 1'b0; bus.rreq_valid = 1'b0; bus.rresp_valid = 1'b0;
    bus.wreq_valid = 1'b0; bus.fire_en = 1'b0;
  endtask

  // vld = {wreq, rresp, rreq}
  task automatic push(input logic [63:0] d, input logic [2:0] vld, input logic en);
    bus.fwd_ipg_data = d; bus.fwd_en = en;
    {bus.wreq_valid, bus.rresp_valid, bus.rreq_valid} = vld;
    tick();
    idle();
  endtask

  task automatic pop(input logic [1:0] sel);
    bus.fire_type_sel = sel; bus.fire_en = 1'b1;
    tick();
    idle();
  endtask

  task automatic push_pop(input logic [63:0] d, input logic [2:0] vld, input logic [1:0] sel);
    bus.fwd_ipg_data = d; bus.fwd_en = 1'b1;
    {bus.wreq_valid, bus.rresp_valid, bus.rreq_valid} = vld;
    bus.fire_type_sel = sel; bus.fire_en = 1'b1;
    tick();
    idle();
  endtask

  initial begin
    idle();
    bus.fwd_ipg_data = '0;
    bus.fire_type_sel = 2'd0;

    // reset state
    tick(); tick();
    chk("rst_rreq_empty",  64'(bus.rreq_empty),  64'd1);
    chk("rst_rresp_empty", 64'(bus.rresp_empty), 64'd1);
    chk("rst_wreq_empty",  64'(bus.wreq_empty),  64'd1);
    chk("rst_fulls", 64'({bus.rreq_full, bus.rresp_full, bus.wreq_full}), 64'd0);
    chk("rst_rreq_space",  64'(bus.rreq_space),  64'd64);
    chk("rst_rresp_space", 64'(bus.rresp_space), 64'd64);
    chk("rst_wreq_space",  64'(bus.wreq_space),  64'd64);
    chk("rst_data", bus.fire_ipg_data, 64'd0);
    rst = 1'b1;
    tick();

    // routed push/pop on rreq
    push(64'h0f1af01fffffff1a, 3'b001, 1'b1);
    push(64'h0f1af02fffffff1a, 3'b001, 1'b1);
    bus.fire_type_sel = 2'd0; #1;
    chk("rreq_head0", bus.fire_ipg_data, 64'h0f1af01fffffff1a);
    chk("rreq_space2", 64'(bus.rreq_space), 64'd62);
    pop(2'd0);
    chk("rreq_head1", bus.fire_ipg_data, 64'h0f1af02fffffff1a);
    pop(2'd0);
    chk("rreq_drained_empty", 64'(bus.rreq_empty), 64'd1);
    chk("rreq_drained_data", bus.fire_ipg_data, 64'd0);

    // type separation
    push(64'h0f1bf01ffffff1b, 3'b010, 1'b1);
    push(64'h2f1cf01ffffff1c, 3'b100, 1'b1);
    bus.fire_type_sel = 2'd1; #1;
    chk("sel1_data", bus.fire_ipg_data, 64'h0f1bf01ffffff1b);
    bus.fire_type_sel = 2'd2; #1;
    chk("sel2_data", bus.fire_ipg_data, 64'h2f1cf01ffffff1c);
    bus.fire_type_sel = 2'd0; #1;
    chk("sel0_data", bus.fire_ipg_data, 64'd0);
    pop(2'd3);
    chk("sel3_data", bus.fire_ipg_data, 64'd0);
    chk("sel3_rresp_space", 64'(bus.rresp_space), 64'd63);
    chk("sel3_wreq_space",  64'(bus.wreq_space),  64'd63);
    pop(2'd1);
    pop(2'd2);
    chk("sep_drained", 64'({bus.rreq_empty, bus.rresp_empty, bus.wreq_empty}), 64'd7);

    // gating and multi-valid broadcast
    push(64'h55, 3'b001, 1'b0);
    chk("gate_fwd_en", 64'(bus.rreq_empty), 64'd1);
    push(64'h66, 3'b000, 1'b1);
    chk("gate_no_valid", 64'({bus.rreq_empty, bus.rresp_empty, bus.wreq_empty}), 64'd7);
    push(64'hABCD, 3'b111, 1'b1);
    chk("bcast_spaces", 64'({bus.rreq_space, bus.rresp_space, bus.wreq_space}),
        64'({7'd63, 7'd63, 7'd63}));
    bus.fire_type_sel = 2'd2; #1;
    chk("bcast_wreq_head", bus.fire_ipg_data, 64'hABCD);
    pop(2'd0); pop(2'd1); pop(2'd2);

    // full: 65th push dropped
    for (int i = 0; i < 65; i++) push(64'(i), 3'b100, 1'b1);
    chk("full_flag",  64'(bus.wreq_full),  64'd1);
    chk("full_space", 64'(bus.wreq_space), 64'd0);
    // push+pop while full: push still dropped
    push_pop(64'd999, 3'b100, 2'd2);
    chk("full_pp_space", 64'(bus.wreq_space), 64'd1);
    chk("full_pp_nofull", 64'(bus.wreq_full), 64'd0);
    bus.fire_type_sel = 2'd2;
    for (int i = 1; i < 64; i++) begin
      #1;
      chk("full_order", bus.fire_ipg_data, 64'(i));
      pop(2'd2);
      bus.fire_type_sel = 2'd2;
    end
    chk("full_drained", 64'(bus.wreq_empty), 64'd1);

    // wrap: 20 in/out then 60 in/out crosses the pointer wrap
    for (int i = 0; i < 20; i++) push(64'(200 + i), 3'b100, 1'b1);
    for (int i = 0; i < 20; i++) begin
      bus.fire_type_sel = 2'd2; #1;
      chk("wrap_a_order", bus.fire_ipg_data, 64'(200 + i));
      pop(2'd2);
    end
    for (int i = 0; i < 60; i++) push(64'(300 + i), 3'b100, 1'b1);
    chk("wrap_space", 64'(bus.wreq_space), 64'd4);
    for (int i = 0; i < 60; i++) begin
      bus.fire_type_sel = 2'd2; #1;
      chk("wrap_b_order", bus.fire_ipg_data, 64'(300 + i));
      pop(2'd2);
    end
    chk("wrap_drained", 64'(bus.wreq_empty), 64'd1);

    // simultaneous push+pop on rreq with 3 entries
    push(64'd10, 3'b001, 1'b1);
    push(64'd11, 3'b001, 1'b1);
    push(64'd12, 3'b001, 1'b1);
    push_pop(64'd13, 3'b001, 2'd0);
    chk("pp_space", 64'(bus.rreq_space), 64'd61);
    bus.fire_type_sel = 2'd0; #1;
    chk("pp_head", bus.fire_ipg_data, 64'd11);
    pop(2'd0);
    bus.fire_type_sel = 2'd0; #1;
    chk("pp_order12", bus.fire_ipg_data, 64'd12);
    pop(2'd0);
    bus.fire_type_sel = 2'd0; #1;
    chk("pp_tail13", bus.fire_ipg_data, 64'd13);
    pop(2'd0);
    chk("pp_drained", 64'(bus.rreq_empty), 64'd1);

    // asynchronous reset mid-fill empties at once
    for (int i = 0; i < 5; i++) push(64'(500 + i), 3'b011, 1'b1);
    chk("midfill_space", 64'(bus.rreq_space), 64'd59);
    #2 rst = 1'b0;
    #1;
    chk("midrst_rreq_empty",  64'(bus.rreq_empty),  64'd1);
    chk("midrst_rresp_space", 64'(bus.rresp_space), 64'd64);
    bus.fire_type_sel = 2'd0; #1;
    chk("midrst_data", bus.fire_ipg_data, 64'd0);
    tick();
    rst = 1'b1;
    tick();
    push(64'h77, 3'b001, 1'b1);
    bus.fire_type_sel = 2'd0; #1;
    chk("post_rst_head", bus.fire_ipg_data, 64'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
